// File: rtl/controle_envase_param_pkg.sv
// Shared state codes, widths and BCD helpers for the bottling-line controller.
package controle_envase_param_pkg;

  localparam int unsigned EST_W = 3;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned N_DIG = 3;
  localparam int unsigned BCD_W = N_DIG * DIG_W;

  localparam logic [EST_W-1:0] EST_DESLIGADO   = 3'd0;
  localparam logic [EST_W-1:0] EST_AVANCA      = 3'd1;
  localparam logic [EST_W-1:0] EST_ENCHE       = 3'd2;
  localparam logic [EST_W-1:0] EST_AVANCA_VEDA = 3'd3;
  localparam logic [EST_W-1:0] EST_VEDA        = 3'd4;
  localparam logic [EST_W-1:0] EST_AVANCA_CQ   = 3'd5;
  localparam logic [EST_W-1:0] EST_INSPECIONA  = 3'd6;
  localparam logic [EST_W-1:0] EST_ALARME      = 3'd7;

  // Elaboration-time encoding of an integer parameter as three BCD digits.
  function automatic logic [BCD_W-1:0] bcd_const(input int unsigned v);
    return {DIG_W'((v / 100) % 10), DIG_W'((v / 10) % 10), DIG_W'(v % 10)};
  endfunction

  function automatic logic [BCD_W-1:0] bcd_add(input logic [BCD_W-1:0] a,
                                               input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [DIG_W:0]   s;
    logic             cy;
    r  = '0;
    cy = 1'b0;
    for (int i = 0; i < int'(N_DIG); i++) begin
      s = 5'(a[i*DIG_W +: DIG_W]) + 5'(b[i*DIG_W +: DIG_W]) + 5'(cy);
      if (s >= 5'd10) begin
        r[i*DIG_W +: DIG_W] = 4'(s - 5'd10);
        cy = 1'b1;
      end else begin
        r[i*DIG_W +: DIG_W] = s[DIG_W-1:0];
        cy = 1'b0;
      end
    end
    return r;
  endfunction

  // Decrement by one, holding at zero.
  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    logic             done;
    r    = a;
    done = (a == '0);
    for (int i = 0; i < int'(N_DIG); i++) begin
      if (!done) begin
        if (r[i*DIG_W +: DIG_W] != '0) begin
          r[i*DIG_W +: DIG_W] = r[i*DIG_W +: DIG_W] - 4'd1;
          done = 1'b1;
        end else begin
          r[i*DIG_W +: DIG_W] = 4'd9;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/controle_envase_param_if.sv
// Sensor/button pulses in, actuator and display signals out.
interface controle_envase_param_if;
  import controle_envase_param_pkg::*;

  logic             start, PG, CH, RO, CQ, EB, rolha_add, alarme_ack;
  logic             MOTOR, EV, VE, ALARME, ligado, lote_completo;
  logic [EST_W-1:0] estado;
  logic [DIG_W-1:0] pacotes_dez, pacotes_uni, rolhas_dez, rolhas_uni;

  modport master (
    output start, PG, CH, RO, CQ, EB, rolha_add, alarme_ack,
    input  MOTOR, EV, VE, ALARME, ligado, lote_completo, estado,
           pacotes_dez, pacotes_uni, rolhas_dez, rolhas_uni
  );

  modport slave (
    input  start, PG, CH, RO, CQ, EB, rolha_add, alarme_ack,
    output MOTOR, EV, VE, ALARME, ligado, lote_completo, estado,
           pacotes_dez, pacotes_uni, rolhas_dez, rolhas_uni
  );
endinterface

// File: rtl/controle_envase_param_contador_bcd_sinc.sv
// Two-digit BCD counter: increment, decrement, add-constant, saturation ceiling, wrap limit.
module controle_envase_param_contador_bcd_sinc
  import controle_envase_param_pkg::*;
#(
  parameter int unsigned INICIAL = 0,
  parameter int unsigned ADICAO  = 1,
  parameter int unsigned MAXIMO  = 99,
  parameter int unsigned LIMITE  = 100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             add_i,
  output logic [DIG_W-1:0] dez_o,
  output logic [DIG_W-1:0] uni_o,
  output logic             wrap_c
);

  localparam logic [BCD_W-1:0] INI_BCD = bcd_const(INICIAL);
  localparam logic [BCD_W-1:0] ADD_BCD = bcd_const(ADICAO);
  localparam logic [BCD_W-1:0] MAX_BCD = bcd_const(MAXIMO);
  localparam logic [BCD_W-1:0] LIM_BCD = bcd_const(LIMITE);

  logic [2*DIG_W-1:0] valor_q, valor_d;
  logic [BCD_W-1:0]   soma;

  // Hundreds digit absorbs overflow so add-then-decrement saturates on the net result.
  always_comb begin
    soma   = {DIG_W'(0), valor_q};
    wrap_c = 1'b0;
    if (add_i) soma = bcd_add(soma, ADD_BCD);
    if (inc_i) soma = bcd_add(soma, BCD_W'(1));
    if (dec_i) soma = bcd_dec(soma);
    if (soma > MAX_BCD) soma = MAX_BCD;
    if (inc_i && (soma >= LIM_BCD)) begin
      soma   = '0;
      wrap_c = 1'b1;
    end
    valor_d = soma[2*DIG_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) valor_q <= INI_BCD[2*DIG_W-1:0];
    else       valor_q <= valor_d;
  end

  assign dez_o = valor_q[2*DIG_W-1:DIG_W];
  assign uni_o = valor_q[DIG_W-1:0];

endmodule

// File: rtl/controle_envase_param.sv
// Bottling-line sequencer: fill, seal, inspect; bottle/pack/cork bookkeeping with alarm.
module controle_envase_param
  import controle_envase_param_pkg::*;
#(
  parameter int unsigned GARRAFAS_POR_PACOTE = 12,
  parameter int unsigned PACOTES_POR_LOTE    = 10,
  parameter int unsigned ROLHAS_MAX          = 99,
  parameter int unsigned ROLHAS_REPOSICAO    = 15,
  parameter int unsigned ROLHAS_INICIAL      = 99,
  parameter int unsigned TIMEOUT_ENCHE       = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  controle_envase_param_if.slave  bus
);

  localparam int unsigned GARR_W = 4;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_ENCHE);

  logic [EST_W-1:0]  estado_q, estado_d;
  logic              ligado_q, ligado_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              eb_q, eb_d;
  logic [GARR_W-1:0] garrafas_q, garrafas_d;
  logic              motor_q, ev_q, ve_q, alarme_q, lote_q;
  logic              aprova, veda_dec, pacote_inc, pacote_wrap_c, rolhas_wrap_unused;
  logic [DIG_W-1:0]  pac_dez, pac_uni, rol_dez, rol_uni;
  logic              sem_rolhas;

  assign sem_rolhas = (rol_dez == '0) && (rol_uni == '0);

  always_comb begin
    estado_d   = estado_q;
    ligado_d   = ligado_q;
    tmr_d      = tmr_q;
    eb_d       = eb_q;
    garrafas_d = garrafas_q;
    aprova     = 1'b0;
    veda_dec   = 1'b0;
    pacote_inc = 1'b0;

    if (bus.start && (estado_q != EST_ALARME)) ligado_d = ~ligado_q;

    case (estado_q)
      EST_DESLIGADO:   if (ligado_d) estado_d = EST_AVANCA;
      EST_AVANCA:      if (bus.PG) begin
                         estado_d = EST_ENCHE;
                         tmr_d    = '0;
                       end
      EST_ENCHE:       if (bus.CH) estado_d = EST_AVANCA_VEDA;
                       else if (tmr_q == TMR_W'(TIMEOUT_ENCHE - 1)) estado_d = EST_ALARME;
                       else tmr_d = tmr_q + TMR_W'(1);
      EST_AVANCA_VEDA: if (bus.RO) estado_d = sem_rolhas ? EST_ALARME : EST_VEDA;
      EST_VEDA:        begin
                         veda_dec = 1'b1;
                         estado_d = EST_AVANCA_CQ;
                       end
      EST_AVANCA_CQ:   if (bus.CQ) begin
                         eb_d     = bus.EB;
                         estado_d = EST_INSPECIONA;
                       end
      EST_INSPECIONA:  begin
                         aprova   = eb_q;
                         estado_d = EST_AVANCA;
                       end
      EST_ALARME:      if (bus.alarme_ack && !sem_rolhas) estado_d = EST_AVANCA;
    endcase

    // Switching the line off wins over any sequencing decision.
    if (ligado_q && !ligado_d) estado_d = EST_DESLIGADO;

    if (aprova) begin
      if (garrafas_q == GARR_W'(GARRAFAS_POR_PACOTE - 1)) begin
        garrafas_d = '0;
        pacote_inc = 1'b1;
      end else begin
        garrafas_d = garrafas_q + GARR_W'(1);
      end
    end
  end

  // Actuators decoded from the next state so they line up with estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= EST_DESLIGADO;
      ligado_q   <= 1'b0;
      tmr_q      <= '0;
      eb_q       <= 1'b0;
      garrafas_q <= '0;
      motor_q    <= 1'b0;
      ev_q       <= 1'b0;
      ve_q       <= 1'b0;
      alarme_q   <= 1'b0;
      lote_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      ligado_q   <= ligado_d;
      tmr_q      <= tmr_d;
      eb_q       <= eb_d;
      garrafas_q <= garrafas_d;
      motor_q    <= (estado_d == EST_AVANCA) || (estado_d == EST_AVANCA_VEDA) ||
                    (estado_d == EST_AVANCA_CQ);
      ev_q       <= (estado_d == EST_ENCHE);
      ve_q       <= (estado_d == EST_VEDA);
      alarme_q   <= (estado_d == EST_ALARME);
      lote_q     <= pacote_wrap_c;
    end
  end

  controle_envase_param_contador_bcd_sinc #(
    .INICIAL(0), .ADICAO(0), .MAXIMO(99), .LIMITE(PACOTES_POR_LOTE)
  ) u_pacotes (
    .clock(clock), .reset(reset), .inc_i(pacote_inc), .dec_i(1'b0), .add_i(1'b0),
    .dez_o(pac_dez), .uni_o(pac_uni), .wrap_c(pacote_wrap_c)
  );

  controle_envase_param_contador_bcd_sinc #(
    .INICIAL(ROLHAS_INICIAL), .ADICAO(ROLHAS_REPOSICAO), .MAXIMO(ROLHAS_MAX), .LIMITE(100)
  ) u_rolhas (
    .clock(clock), .reset(reset), .inc_i(1'b0), .dec_i(veda_dec), .add_i(bus.rolha_add),
    .dez_o(rol_dez), .uni_o(rol_uni), .wrap_c(rolhas_wrap_unused)
  );

  assign bus.MOTOR         = motor_q;
  assign bus.EV            = ev_q;
  assign bus.VE            = ve_q;
  assign bus.ALARME        = alarme_q;
  assign bus.ligado        = ligado_q;
  assign bus.estado        = estado_q;
  assign bus.lote_completo = lote_q;
  assign bus.pacotes_dez   = pac_dez;
  assign bus.pacotes_uni   = pac_uni;
  assign bus.rolhas_dez    = rol_dez;
  assign bus.rolhas_uni    = rol_uni;

endmodule

// File: tb/tb_controle_envase_param.sv
// Bench for controle_envase_param: vector table, directed corner sequences, random vs. model.
module tb_controle_envase_param;

  localparam int unsigned T_ENCHE = 1000;

  typedef struct packed {
    logic start, pg, ch, ro, cq, eb, radd, ack;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [2:0] est;
    logic [2:0] mev;
    logic [7:0] rol;
  } vec_t;

  localparam stim_t S_NONE  = 8'b0000_0000;
  localparam stim_t S_START = 8'b1000_0000;
  localparam stim_t S_PG    = 8'b0100_0000;
  localparam stim_t S_CH    = 8'b0010_0000;
  localparam stim_t S_RO    = 8'b0001_0000;
  localparam stim_t S_CQ    = 8'b0000_1000;
  localparam stim_t S_CQEB  = 8'b0000_1100;
  localparam stim_t S_RADD  = 8'b0000_0010;
  localparam stim_t S_ACK   = 8'b0000_0001;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  controle_envase_param_if bus();

  controle_envase_param #(
    .GARRAFAS_POR_PACOTE(12), .PACOTES_POR_LOTE(10), .ROLHAS_MAX(99),
    .ROLHAS_REPOSICAO(15), .ROLHAS_INICIAL(99), .TIMEOUT_ENCHE(T_ENCHE)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int lote_seen = 0;
  int ve_seen = 0;

  // Reference model: line phase number plus integer counts.
  int m_phase, m_wait, m_bot, m_pack, m_cork;
  bit m_lig, m_eb, m_lote;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_bot = 0; m_pack = 0; m_cork = 99;
    m_lig = 0; m_eb = 0; m_lote = 0;
  endtask

  task automatic model_step(input stim_t s);
    int  np, nc;
    bit  nl;
    nl = m_lig;
    if (s.start && m_phase != 7) nl = !m_lig;
    np = m_phase;
    m_lote = 0;
    nc = m_cork + (s.radd ? 15 : 0) - ((m_phase == 4 && m_cork > 0) ? 1 : 0);
    if (nc > 99) nc = 99;
    case (m_phase)
      0: if (nl) np = 1;
      1: if (s.pg) begin np = 2; m_wait = 0; end
      2: if (s.ch) np = 3;
         else begin
           m_wait++;
           if (m_wait == int'(T_ENCHE)) np = 7;
         end
      3: if (s.ro) np = (m_cork == 0) ? 7 : 4;
      4: np = 5;
      5: if (s.cq) begin m_eb = s.eb; np = 6; end
      6: begin
           if (m_eb) begin
             m_bot++;
             if (m_bot == 12) begin
               m_bot = 0;
               m_pack++;
               if (m_pack == 10) begin m_pack = 0; m_lote = 1; end
             end
           end
           np = 1;
         end
      default: if (s.ack && m_cork > 0) np = 1;
    endcase
    if (m_lig && !nl) np = 0;
    m_phase = np; m_lig = nl; m_cork = nc;
  endtask

  function automatic logic [31:0] model_vec();
    bit mo;
    mo = (m_phase == 1) || (m_phase == 3) || (m_phase == 5);
    return {7'd0, 3'(m_phase), mo, m_phase == 2, m_phase == 4, m_phase == 7, m_lig, m_lote,
            4'(m_pack / 10), 4'(m_pack % 10), 4'(m_cork / 10), 4'(m_cork % 10)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {7'd0, bus.estado, bus.MOTOR, bus.EV, bus.VE, bus.ALARME, bus.ligado,
            bus.lote_completo, bus.pacotes_dez, bus.pacotes_uni, bus.rolhas_dez, bus.rolhas_uni};
  endfunction

  task automatic drive(input stim_t s);
    {bus.start, bus.PG, bus.CH, bus.RO, bus.CQ, bus.EB, bus.rolha_add, bus.alarme_ack} = s;
  endtask

  task automatic tick(input stim_t s);
    drive(s);
    @(posedge clock);
    model_step(s);
    #1;
    if (bus.lote_completo) lote_seen++;
    if (bus.VE) ve_seen++;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(S_NONE);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic bottle(input bit eb, input bit refill);
    tick(S_PG);
    tick(S_CH);
    tick(S_RO);
    tick(refill ? S_RADD : S_NONE);
    tick(eb ? S_CQEB : S_CQ);
    tick(S_NONE);
  endtask

  function automatic logic [31:0] rolhas_bcd();
    return {24'd0, bus.rolhas_dez, bus.rolhas_uni};
  endfunction

  function automatic logic [31:0] pacotes_bcd();
    return {24'd0, bus.pacotes_dez, bus.pacotes_uni};
  endfunction

  vec_t vecs[9];

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{S_START, 3'd1, 3'b100, 8'h99};
    vecs[1] = '{S_PG,    3'd2, 3'b010, 8'h99};
    vecs[2] = '{S_CH,    3'd3, 3'b100, 8'h99};
    vecs[3] = '{S_RO,    3'd4, 3'b001, 8'h99};
    vecs[4] = '{S_NONE,  3'd5, 3'b100, 8'h98};
    vecs[5] = '{S_CQEB,  3'd6, 3'b000, 8'h98};
    vecs[6] = '{S_NONE,  3'd1, 3'b100, 8'h98};
    vecs[7] = '{S_CQ,    3'd1, 3'b100, 8'h98};
    vecs[8] = '{S_CH,    3'd1, 3'b100, 8'h98};

    do_reset();
    chk("rst_estado", 32'(bus.estado), 32'd0);
    chk("rst_outs", 32'({bus.MOTOR, bus.EV, bus.VE, bus.ALARME, bus.lote_completo}), 32'd0);
    chk("rst_ligado", 32'(bus.ligado), 32'd0);
    chk("rst_pacotes", pacotes_bcd(), 32'h00);
    chk("rst_rolhas", rolhas_bcd(), 32'h99);

    // First bottle through the table: VE one cycle, corks 99 -> 98, back to AVANCA.
    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].s);
      chk($sformatf("vec%0d_estado", i), 32'(bus.estado), 32'(vecs[i].est));
      chk($sformatf("vec%0d_mev", i), 32'({bus.MOTOR, bus.EV, bus.VE}), 32'(vecs[i].mev));
      chk($sformatf("vec%0d_rolhas", i), rolhas_bcd(), 32'(vecs[i].rol));
    end

    // Rejected bottle: no count, cork still consumed.
    bottle(1'b0, 1'b0);
    chk("reject_rolhas", rolhas_bcd(), 32'h97);
    for (int i = 0; i < 10; i++) bottle(1'b1, 1'b0);
    chk("pack_before_12", pacotes_bcd(), 32'h00);
    bottle(1'b1, 1'b0);
    chk("pack_after_12", pacotes_bcd(), 32'h01);
    chk("rolhas_after_13", rolhas_bcd(), 32'h86);

    // Up to 120 approved bottles: pack wraps 09 -> 00 with one lote pulse.
    for (int i = 0; i < 107; i++) bottle(1'b1, m_cork < 20);
    chk("pack_119", pacotes_bcd(), 32'h09);
    lote_seen = 0;
    bottle(1'b1, 1'b0);
    chk("pack_wrap", pacotes_bcd(), 32'h00);
    chk("lote_pulses", 32'(lote_seen), 32'd1);

    // Saturating refill coinciding with a seal.
    repeat (7) tick(S_RADD);
    chk("rolhas_full", rolhas_bcd(), 32'h99);
    for (int i = 0; i < 9; i++) bottle(1'b1, 1'b0);
    chk("rolhas_90", rolhas_bcd(), 32'h90);
    bottle(1'b1, 1'b1);
    chk("rolhas_sat", rolhas_bcd(), 32'h99);

    // Out of corks: alarm instead of sealing.
    for (int i = 0; i < 99; i++) bottle(1'b0, 1'b0);
    chk("rolhas_zero", rolhas_bcd(), 32'h00);
    ve_seen = 0;
    tick(S_PG);
    tick(S_CH);
    tick(S_RO);
    chk("nocork_estado", 32'(bus.estado), 32'd7);
    chk("nocork_alarme", 32'(bus.ALARME), 32'd1);
    repeat (3) tick(S_NONE);
    tick(S_ACK);
    chk("nocork_ack_ignored", 32'(bus.estado), 32'd7);
    tick(S_START);
    chk("nocork_start_ignored", 32'({bus.estado, bus.ligado}), 32'({3'd7, 1'b1}));
    tick(S_RADD);
    chk("nocork_refill", rolhas_bcd(), 32'h15);
    tick(S_ACK);
    chk("nocork_recover", 32'(bus.estado), 32'd1);
    chk("nocork_no_ve", 32'(ve_seen), 32'd0);

    // Fill timeout.
    tick(S_PG);
    repeat (T_ENCHE - 1) tick(S_NONE);
    chk("timeout_not_yet", 32'(bus.estado), 32'd2);
    tick(S_NONE);
    chk("timeout_alarm", 32'({bus.estado, bus.ALARME, bus.EV}), 32'({3'd7, 1'b1, 1'b0}));
    tick(S_START);
    chk("timeout_start_ignored", 32'({bus.estado, bus.ligado}), 32'({3'd7, 1'b1}));
    tick(S_ACK);
    chk("timeout_recover", 32'(bus.estado), 32'd1);

    // Switch-off in the middle of a fill.
    tick(S_PG);
    chk("midfill_ev", 32'(bus.EV), 32'd1);
    tick(S_START);
    chk("midfill_off", 32'({bus.estado, bus.EV, bus.ligado}), 32'd0);

    // Random traffic against the model.
    do_reset();
    tick(S_START);
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s       = S_NONE;
      s.start = ($urandom_range(0, 39) == 0);
      s.pg    = ($urandom_range(0, 2) == 0);
      s.ch    = ($urandom_range(0, 2) == 0);
      s.ro    = ($urandom_range(0, 2) == 0);
      s.cq    = ($urandom_range(0, 2) == 0);
      s.eb    = ($urandom_range(0, 1) == 0);
      s.radd  = ($urandom_range(0, 29) == 0);
      s.ack   = ($urandom_range(0, 9) == 0);
      tick(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
